// File: rtl/psum_channel_acc.sv
// Channel-group psum accumulator: sums CHANNELS partial sums per batch and streams BATCHES results.
// Define PSUM_SAT_EN to clamp results to the signed OUT_W range instead of wrapping.
module psum_channel_acc #(
  parameter int BATCHES  = 4,
  parameter int CHANNELS = 3,
  parameter int IN_W     = 21,
  parameter int OUT_W    = 21,
  parameter int ACC_W    = IN_W + $clog2(CHANNELS) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [IN_W-1:0]  data_in,
  input  logic             data_in_valid,
  output logic             data_in_ready,
  output logic [OUT_W-1:0] data_out,
  output logic             data_out_valid,
  input  logic             data_out_ready,
  output logic             tile_done,
  output logic             busy
);

  localparam int BW = (BATCHES > 1) ? $clog2(BATCHES) : 1;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(BATCHES - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CHANNELS - 1);

`ifdef PSUM_SAT_EN
  localparam logic [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  function automatic logic [OUT_W-1:0] conv(input logic [ACC_W-1:0] a);
    if ($signed(a) > $signed(SAT_MAX)) return SAT_MAX[OUT_W-1:0];
    else if ($signed(a) < $signed(SAT_MIN)) return SAT_MIN[OUT_W-1:0];
    else return a[OUT_W-1:0];
  endfunction
`else
  function automatic logic [OUT_W-1:0] conv(input logic [ACC_W-1:0] a);
    return a[OUT_W-1:0];
  endfunction
`endif

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t           state_reg, state_next;
  logic [BW-1:0]    b_idx_reg, b_idx_next;
  logic [BW-1:0]    d_idx_reg, d_idx_next;
  logic [BW-1:0]    d_idx_inc;
  logic [CW-1:0]    c_idx_reg, c_idx_next;
  logic             any_acc_reg, any_acc_next;
  logic [OUT_W-1:0] data_out_reg, data_out_next;
  logic             out_valid_reg, out_valid_next;
  logic             tile_done_reg, tile_done_next;
  logic [ACC_W-1:0] acc_rd [BATCHES];
  logic [ACC_W-1:0] acc_nx [BATCHES];
  logic             accept;
  logic             last_in;
  logic [ACC_W-1:0] din_ext;

  assign data_in_ready = (state_reg == ACCUM) && en;
  assign accept        = data_in_valid && data_in_ready;
  assign last_in       = accept && (c_idx_reg == C_LAST) && (b_idx_reg == B_LAST);
  assign din_ext       = {{(ACC_W-IN_W){data_in[IN_W-1]}}, data_in};
  assign d_idx_inc     = d_idx_reg + 1'b1;

  // One accumulator per batch; channel 0 overwrites so no explicit clear between tiles is needed.
  genvar gi;
  generate
    for (gi = 0; gi < BATCHES; gi++) begin : g_acc
      logic [ACC_W-1:0] acc_reg, acc_next;

      always_comb begin
        acc_next = acc_reg;
        if (accept && (b_idx_reg == BW'(gi)))
          acc_next = (c_idx_reg == '0) ? din_ext : acc_reg + din_ext;
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) acc_reg <= '0;
        else       acc_reg <= acc_next;
      end

      assign acc_rd[gi] = acc_reg;
      assign acc_nx[gi] = acc_next;
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    b_idx_next     = b_idx_reg;
    c_idx_next     = c_idx_reg;
    d_idx_next     = d_idx_reg;
    any_acc_next   = any_acc_reg;
    data_out_next  = data_out_reg;
    out_valid_next = out_valid_reg;
    tile_done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (en) begin
          state_next   = ACCUM;
          b_idx_next   = '0;
          c_idx_next   = '0;
          d_idx_next   = '0;
          any_acc_next = 1'b0;
        end
      end
      ACCUM: begin
        if (!en) begin
          state_next   = IDLE;
          b_idx_next   = '0;
          c_idx_next   = '0;
          d_idx_next   = '0;
          any_acc_next = 1'b0;
        end else if (accept) begin
          any_acc_next = 1'b1;
          if (b_idx_reg == B_LAST) begin
            b_idx_next = '0;
            c_idx_next = (c_idx_reg == C_LAST) ? '0 : c_idx_reg + 1'b1;
          end else begin
            b_idx_next = b_idx_reg + 1'b1;
          end
          if (last_in) begin
            // acc_nx covers BATCHES==1, where acc[0] is written on this same edge.
            state_next     = DRAIN;
            d_idx_next     = '0;
            data_out_next  = conv(acc_nx[0]);
            out_valid_next = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (data_out_ready) begin
          if (d_idx_reg == B_LAST) begin
            state_next     = en ? ACCUM : IDLE;
            b_idx_next     = '0;
            c_idx_next     = '0;
            d_idx_next     = '0;
            any_acc_next   = 1'b0;
            data_out_next  = '0;
            out_valid_next = 1'b0;
            tile_done_next = 1'b1;
          end else begin
            d_idx_next    = d_idx_inc;
            data_out_next = conv(acc_rd[d_idx_inc]);
          end
        end
      end
      default: begin
        state_next     = IDLE;
        data_out_next  = '0;
        out_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      b_idx_reg     <= '0;
      c_idx_reg     <= '0;
      d_idx_reg     <= '0;
      any_acc_reg   <= 1'b0;
      data_out_reg  <= '0;
      out_valid_reg <= 1'b0;
      tile_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      b_idx_reg     <= b_idx_next;
      c_idx_reg     <= c_idx_next;
      d_idx_reg     <= d_idx_next;
      any_acc_reg   <= any_acc_next;
      data_out_reg  <= data_out_next;
      out_valid_reg <= out_valid_next;
      tile_done_reg <= tile_done_next;
    end
  end

  assign data_out       = data_out_reg;
  assign data_out_valid = out_valid_reg;
  assign tile_done      = tile_done_reg;
  assign busy           = ((state_reg == ACCUM) && any_acc_reg) || (state_reg == DRAIN);

endmodule

// File: tb/tb_psum_channel_acc.sv
// Self-checking bench for psum_channel_acc: directed tiles, uniform-fill table, abort, async reset, random tiles.
module tb_psum_channel_acc;
  localparam int B     = 4;
  localparam int C     = 3;
  localparam int IN_W  = 21;
  localparam int OUT_W = 21;
  localparam int N     = B * C;

  logic clock = 1'b0;
  logic reset, en, data_in_valid, data_in_ready, data_out_valid, data_out_ready, tile_done, busy;
  logic signed [IN_W-1:0]  data_in;
  logic signed [OUT_W-1:0] data_out;

  int passed = 0;
  int total  = 0;

  int     in_buf [N];
  longint exp_arr [B];

  typedef struct packed {
    logic signed [31:0] fill;
    logic signed [31:0] exp_out;
  } vec_t;
  vec_t tab [7];

  always #5 clock = ~clock;

  psum_channel_acc dut (
    .clock         (clock),
    .reset         (reset),
    .en            (en),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .tile_done     (tile_done),
    .busy          (busy)
  );

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Reference: exact integer sum per batch, then clamp or wrap to OUT_W.
  function automatic longint model_conv(input longint s);
    longint lim;
    longint w;
    lim = longint'(1) <<< (OUT_W - 1);
`ifdef PSUM_SAT_EN
    if (s > lim - 1) return lim - 1;
    if (s < -lim) return -lim;
    return s;
`else
    w = s & ((lim << 1) - 1);
    if (w >= lim) w = w - (lim << 1);
    return w;
`endif
  endfunction

  task automatic build_exp();
    for (int b = 0; b < B; b++) begin
      longint s = 0;
      for (int c = 0; c < C; c++) s += longint'(in_buf[c*B + b]);
      exp_arr[b] = model_conv(s);
    end
  endtask

  task automatic load_first_tile();
    for (int c = 0; c < C; c++)
      for (int b = 0; b < B; b++) begin
        int mult = (c == 0) ? 1 : ((c == 1) ? 10 : 100);
        in_buf[c*B + b] = (b + 1) * mult;
      end
    exp_arr[0] = 111; exp_arr[1] = 222; exp_arr[2] = 333; exp_arr[3] = 444;
  endtask

  task automatic send_tile(input int n, input bit gaps);
    int  i = 0;
    int  guard = 0;
    bit  acc;
    while (i < n && guard < 500) begin
      data_in       = IN_W'(in_buf[i]);
      data_in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clock);
      acc = data_in_valid && data_in_ready;
      @(posedge clock); #1;
      if (acc) i++;
      guard++;
    end
    data_in_valid = 1'b0;
    check("inputs_accepted", i, n);
  endtask

  // mode 0: ready high, 1: ready pattern 1,0,0,..., 2: random ready
  task automatic recv_tile(input int mode);
    int  k = 0;
    int  cyc = 0;
    bit  prev_stall = 1'b0;
    bit  first = 1'b1;
    logic signed [OUT_W-1:0] prev = '0;
    while (k < B && cyc < 300) begin
      case (mode)
        0:       data_out_ready = 1'b1;
        1:       data_out_ready = (cyc % 3 == 0);
        default: data_out_ready = ($urandom_range(0, 1) == 1);
      endcase
      @(negedge clock);
      if (first) check("first_valid_latency", data_out_valid, 1);
      first = 1'b0;
      if (prev_stall) begin
        check("stall_valid", data_out_valid, 1);
        check("stall_hold", data_out, prev);
      end
      if (data_out_valid) check("in_ready_in_drain", data_in_ready, 0);
      else                check("out_zero_when_invalid", data_out, 0);
      check("no_early_done", tile_done, 0);
      if (data_out_valid && data_out_ready) begin
        $display("out[%0d] = %0d (expected %0d)", k, data_out, exp_arr[k]);
        check($sformatf("out[%0d]", k), data_out, exp_arr[k]);
        k++;
      end
      prev_stall = data_out_valid && !data_out_ready;
      prev       = data_out;
      @(posedge clock); #1;
      cyc++;
    end
    check("outputs_seen", k, B);
    @(negedge clock);
    check("tile_done_pulse", tile_done, 1);
    check("busy_after_tile", busy, 0);
    check("valid_after_tile", data_out_valid, 0);
    @(posedge clock); #1;
    @(negedge clock);
    check("tile_done_single", tile_done, 0);
    @(posedge clock); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tab[0] = '{fill: -5,       exp_out: -15};
    tab[1] = '{fill: 0,        exp_out: 0};
    tab[2] = '{fill: 349525,   exp_out: 1048575};
`ifdef PSUM_SAT_EN
    tab[3] = '{fill: 1000000,  exp_out: 1048575};
    tab[4] = '{fill: -1000000, exp_out: -1048576};
    tab[5] = '{fill: 1048575,  exp_out: 1048575};
    tab[6] = '{fill: 349526,   exp_out: 1048575};
`else
    tab[3] = '{fill: 1000000,  exp_out: 902848};
    tab[4] = '{fill: -1000000, exp_out: -902848};
    tab[5] = '{fill: 1048575,  exp_out: 1048573};
    tab[6] = '{fill: 349526,   exp_out: -1048574};
`endif

    reset = 1'b1; en = 1'b0; data_in_valid = 1'b0; data_in = '0; data_out_ready = 1'b0;
    #12;
    check("rst_in_ready", data_in_ready, 0);
    check("rst_data_out", data_out, 0);
    check("rst_valid", data_out_valid, 0);
    check("rst_tile_done", tile_done, 0);
    check("rst_busy", busy, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    $display("tile: directed, ready high");
    en = 1'b1;
    load_first_tile();
    send_tile(N, 1'b0);
    recv_tile(0);

    $display("tile: directed, ready stalls");
    load_first_tile();
    send_tile(N, 1'b0);
    recv_tile(1);

    // Uniform-fill tiles back-to-back with en held high
    for (int t = 0; t < 7; t++) begin
      $display("tile: fill %0d", tab[t].fill);
      for (int i = 0; i < N; i++) in_buf[i] = int'(tab[t].fill);
      for (int b = 0; b < B; b++) exp_arr[b] = longint'(tab[t].exp_out);
      send_tile(N, 1'b0);
      recv_tile(0);
    end

    $display("tile: abort after 6 inputs");
    load_first_tile();
    send_tile(6, 1'b0);
    check("busy_mid_accum", busy, 1);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("abort_no_valid", data_out_valid, 0);
      check("abort_no_done", tile_done, 0);
      check("abort_in_ready", data_in_ready, 0);
      if (i > 0) check("abort_busy", busy, 0);
      @(posedge clock); #1;
    end
    en = 1'b1;
    send_tile(N, 1'b0);
    recv_tile(0);

    $display("tile: async reset mid-drain");
    load_first_tile();
    send_tile(N, 1'b0);
    data_out_ready = 1'b0;
    @(negedge clock);
    check("drain_reached", data_out_valid, 1);
    #2 reset = 1'b1;
    en = 1'b0;
    #1;
    check("arst_valid", data_out_valid, 0);
    check("arst_data_out", data_out, 0);
    check("arst_busy", busy, 0);
    check("arst_in_ready", data_in_ready, 0);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    en = 1'b1;
    send_tile(N, 1'b0);
    recv_tile(0);

    for (int t = 0; t < 6; t++) begin
      $display("tile: random %0d", t);
      for (int i = 0; i < N; i++) in_buf[i] = int'($urandom_range(0, 2097151)) - 1048576;
      build_exp();
      send_tile(N, 1'b1);
      recv_tile(2);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/psum_channel_acc.md
Name: psum_channel_acc

Overview:
- Parametrised successor of the fixed 4-batch / 3-channel psum output accumulator.
- Sits between the psum SRAM read-out and the output/ofmap writer.
- Sums partial sums across CHANNELS input-channel groups for each of BATCHES batches and streams one final sum per batch.
- Adds ready/valid backpressure on both sides, tile abort, a done pulse, and optional output saturation.

Parameters:
- BATCHES, 4, batches per channel group (>=1)
- CHANNELS, 3, channel groups summed per tile (>=1)
- IN_W, 21, signed input psum width
- OUT_W, 21, signed output width (OUT_W <= ACC_W)
- ACC_W, IN_W+$clog2(CHANNELS)+1, internal accumulator width; sized so the internal sum never overflows

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- en  in  1  tile enable; level-sensitive
- data_in  in  IN_W  signed partial sum
- data_in_valid  in  1  data_in qualifier
- data_in_ready  out  1  block accepts data_in this cycle
- data_out  out  OUT_W  signed final batch sum
- data_out_valid  out  1  data_out qualifier
- data_out_ready  in  1  downstream accepts data_out
- tile_done  out  1  one-cycle pulse on the last output handshake of a tile
- busy  out  1  high in ACCUM with at least one input accepted, or in DRAIN

Behaviour:
- Input order is channel-major: c0b0, c0b1 … c0b(B-1), c1b0 … c(C-1)b(B-1).
- Counters: b_idx (0..BATCHES-1), c_idx (0..CHANNELS-1), d_idx (0..BATCHES-1); each wraps to 0.
- Accumulator bank acc[0..BATCHES-1], each ACC_W wide, sign-extended on input.
- Input accept = data_in_valid & data_in_ready.
  - When c_idx==0, the accept overwrites acc[b_idx].
  - Otherwise it adds: acc[b_idx] <= acc[b_idx] + sext(data_in).
- FSM states: IDLE, ACCUM, DRAIN. Reset state is IDLE.
  - IDLE: data_in_ready=0. When en=1, go to ACCUM next cycle and clear all counters.
  - ACCUM: data_in_ready=en. On accepting the input with c_idx==CHANNELS-1 and b_idx==BATCHES-1, go to DRAIN.
  - DRAIN: data_in_ready=0, data_out_valid=1. data_out = conv(acc[d_idx]), where conv is defined below.
    - Each handshake (data_out_valid & data_out_ready) advances d_idx.
    - The handshake with d_idx==BATCHES-1 pulses tile_done next cycle, clears counters, and goes to ACCUM if en=1, else IDLE.
- Latency: first data_out_valid occurs 1 cycle after the last input accept.
  - With data_out_ready held high, outputs are back-to-back: BATCHES cycles.
  - Throughput is 1 input per cycle in ACCUM.
- data_out and data_out_valid are registered outputs.
  - data_out holds its value while valid is high and ready is low.
  - data_out is 0 whenever valid is low.
- en deasserted in ACCUM: abort. Go to IDLE next cycle, clear counters, no output, no tile_done. acc contents are don't-care.
- en deasserted in DRAIN: the drain completes, then go to IDLE.
- Reset mid-operation: all outputs go to 0 immediately (asynchronous), FSM goes to IDLE, counters go to 0, acc goes to 0.
- Reset values: data_in_ready=0, data_out=0, data_out_valid=0, tile_done=0, busy=0.
- CHANNELS==1: each acc is a pure copy of its input. BATCHES==1: d_idx is constant 0. Both are legal.

Optional Feature:
- Macro: PSUM_SAT_EN.
- Defined: conv clamps the ACC_W value to the signed OUT_W range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Undefined: conv takes the low OUT_W bits (two's-complement wrap). No clamp logic is generated.

Test Plan:
- Defaults, data_out_ready=1; inputs c0: 1,2,3,4; c1: 10,20,30,40; c2: 100,200,300,400 -> data_out 111,222,333,444 on 4 consecutive cycles starting 1 cycle after the last input; tile_done pulses once; busy falls after the pulse.
- Same stimulus with data_out_ready toggling 1,0,0,1,… -> each value held stable while stalled; order 111,222,333,444; data_in_ready=0 throughout DRAIN.
- Two tiles back-to-back with en held high; tile 2 all inputs = -5 -> outputs -15 ×4; no residue from tile 1 (channel-0 overwrite checked).
- Overflow: every input = 1,000,000 -> each output 1,048,575 with PSUM_SAT_EN defined; 902,848 with PSUM_SAT_EN undefined. Negative case: every input = -1,000,000 -> -1,048,576 saturated.
- Abort: drop en after 6 inputs -> IDLE next cycle, no data_out_valid, no tile_done; re-enable and send a full tile -> correct sums.
- Asynchronous reset asserted mid-DRAIN, between clock edges -> data_out_valid=0 and data_out=0 immediately; after release, a full tile with inputs as in the first scenario yields 111,222,333,444.
